// File: rtl/dom1_skinny_ctrl.sv
// Job sequencer for the DOM-1 masked SKINNY-128-384+ core: buffers PRNG words, loads and runs the core,
// hands back result shares; mask starvation aborts the job (sticky err) since the core cannot stall.
module dom1_skinny_ctrl #(
  parameter int RND_DEPTH   = 4,
  parameter int RND_PREFILL = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_ssh0,
  input  logic [127:0] in_ssh1,
  input  logic [127:0] in_ksh0,
  input  logic [127:0] in_ksh1,
  input  logic [127:0] in_tweak,
  input  logic [127:0] in_cnt,
  input  logic         rnd_valid,
  output logic         rnd_ready,
  input  logic [127:0] rnd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ssh0,
  output logic [127:0] out_ssh1,
  output logic         err,
  output logic         core_rst,
  output logic [127:0] core_sshi0,
  output logic [127:0] core_sshi1,
  output logic [127:0] core_kshi0,
  output logic [127:0] core_kshi1,
  output logic [127:0] core_ti,
  output logic [127:0] core_cnti,
  output logic [127:0] core_ri,
  input  logic [127:0] core_sshr0,
  input  logic [127:0] core_sshr1,
  input  logic         core_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam int PW = $clog2(RND_DEPTH);
  localparam int CW = $clog2(RND_DEPTH + 1);

  logic [1:0]    state;
  logic [2:0]    phase;
  logic [127:0]  mem [RND_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;
  logic          underflow;
  logic          ri_slot;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RND_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Phase 4 is the round boundary where the core samples core_ri.
  assign ri_slot   = (state == S_RUN) && (phase == 3'd4);
  assign underflow = ri_slot && (count == '0);
  assign pop       = ((state == S_FILL) && (count >= CW'(RND_PREFILL))) ||
                     (ri_slot && (count != '0));
  // A full FIFO still takes a word in the cycle its head is consumed.
  assign rnd_ready = (count < CW'(RND_DEPTH)) || pop;
  assign push      = rnd_valid && rnd_ready;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT);
  assign core_rst  = (state != S_RUN);
  assign core_ri   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rnd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= '0;
      err        <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      core_sshi0 <= '0;
      core_sshi1 <= '0;
      core_kshi0 <= '0;
      core_kshi1 <= '0;
      core_ti    <= '0;
      core_cnti  <= '0;
      out_ssh0   <= '0;
      out_ssh1   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            core_sshi0 <= in_ssh0;
            core_sshi1 <= in_ssh1;
            core_kshi0 <= in_ksh0;
            core_kshi1 <= in_ksh1;
            core_ti    <= in_tweak;
            core_cnti  <= in_cnt;
            state      <= S_FILL;
          end
        end
        S_FILL: begin
          if (pop) begin
            state <= S_RUN;
            phase <= '0;
          end
        end
        S_RUN: begin
          phase <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
          if (underflow) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else if (core_done) begin
            out_ssh0 <= core_sshr0;
            out_ssh1 <= core_sshr1;
            state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dom1_skinny_ctrl.sv
// Randomized bench for dom1_skinny_ctrl with a queue-based reference model and mask-word scoreboard.
module tb_dom1_skinny_ctrl;
  localparam int DEPTH = 4;
  localparam int PRE   = 2;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready, err, core_rst, core_done;
  logic [127:0] in_ssh0, in_ssh1, in_ksh0, in_ksh1, in_tweak, in_cnt, rnd_data, out_ssh0, out_ssh1;
  logic [127:0] core_sshi0, core_sshi1, core_kshi0, core_kshi1, core_ti, core_cnti, core_ri;
  logic [127:0] core_sshr0, core_sshr1;

  always #5 clk = ~clk;

  dom1_skinny_ctrl #(.RND_DEPTH(DEPTH), .RND_PREFILL(PRE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ssh0(in_ssh0), .in_ssh1(in_ssh1), .in_ksh0(in_ksh0), .in_ksh1(in_ksh1),
    .in_tweak(in_tweak), .in_cnt(in_cnt), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .rnd_data(rnd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ssh0(out_ssh0), .out_ssh1(out_ssh1), .err(err), .core_rst(core_rst),
    .core_sshi0(core_sshi0), .core_sshi1(core_sshi1), .core_kshi0(core_kshi0),
    .core_kshi1(core_kshi1), .core_ti(core_ti), .core_cnti(core_cnti), .core_ri(core_ri),
    .core_sshr0(core_sshr0), .core_sshr1(core_sshr1), .core_done(core_done)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: job mode (0 idle, 1 fill, 2 run, 3 out), round phase, mask FIFO as a queue.
  int m_mode = 0;
  int m_phase = 0;
  logic [127:0] m_q[$];
  logic [127:0] m_used[$];
  bit m_pop, m_und, m_push;

  logic [127:0] job [6];

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
      m_phase = 0;
      m_q.delete();
    end else begin
      m_pop  = (m_mode == 1 && m_q.size() >= PRE) || (m_mode == 2 && m_phase == 4 && m_q.size() > 0);
      m_und  = (m_mode == 2 && m_phase == 4 && m_q.size() == 0);
      m_push = rnd_valid && (m_q.size() < DEPTH || m_pop);
      if (m_pop) begin
        n_chk++;
        if (core_ri !== m_q[0]) $display("FAIL mask_word got %h want %h", core_ri, m_q[0]);
        else n_pass++;
        m_used.push_back(m_q.pop_front());
      end
      if (m_push) m_q.push_back(rnd_data);
      case (m_mode)
        0: if (in_valid) m_mode = 1;
        1: if (m_pop) begin m_mode = 2; m_phase = 0; end
        2: begin
          if (m_und) m_mode = 0;
          else if (core_done) m_mode = 3;
          else m_phase = (m_phase + 1) % 5;
        end
        3: if (out_ready) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rnd_data = r128();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0; core_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_job();
    for (int i = 0; i < 6; i++) job[i] = r128();
    in_ssh0 = job[0]; in_ssh1 = job[1]; in_ksh0 = job[2];
    in_ksh1 = job[3]; in_tweak = job[4]; in_cnt = job[5];
  endtask

  task automatic wait_run(output int n);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (!core_rst) begin n = k; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0; core_done = 1'b0;
    core_sshr0 = '0; core_sshr1 = '0; rnd_data = '0; set_job();
    tick(); tick();
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else n_pass++;
    n_chk++; if (core_rst !== 1'b1) $display("FAIL rst_core_rst got %b want 1", core_rst); else n_pass++;
    n_chk++; if ({out_ssh0, out_ssh1, core_sshi0, core_ti} !== '0) $display("FAIL rst_regs got nonzero want 0"); else n_pass++;
    n_chk++; if (rnd_ready !== 1'b1) $display("FAIL rst_rnd_ready got %b want 1", rnd_ready); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int n;
    logic [127:0] r0, r1;
    do_reset();
    rnd_valid = 1'b1;
    repeat (5) tick();
    set_job(); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    n_chk++; if ({core_sshi0, core_sshi1, core_kshi0, core_kshi1, core_ti, core_cnti} !== {job[0], job[1], job[2], job[3], job[4], job[5]})
      $display("FAIL nom_job_regs got %h want %h", core_sshi0, job[0]); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL nom_in_ready_busy got %b want 0", in_ready); else n_pass++;
    wait_run(n);
    n_chk++; if (n != 1) $display("FAIL nom_run_start got %0d want 1", n); else n_pass++;
    repeat (12) tick();
    n_chk++; if (m_used.size() != 3) $display("FAIL nom_pop_count got %0d want 3", m_used.size()); else n_pass++;
    r0 = r128(); r1 = r128();
    core_sshr0 = r0; core_sshr1 = r1; core_done = 1'b1;
    tick(); core_done = 1'b0; core_sshr0 = r128(); core_sshr1 = r128();
    n_chk++; if (out_valid !== 1'b1) $display("FAIL nom_out_valid got %b want 1", out_valid); else n_pass++;
    n_chk++; if ({out_ssh0, out_ssh1} !== {r0, r1}) $display("FAIL nom_result got %h want %h", out_ssh0, r0); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL nom_err got %b want 0", err); else n_pass++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_chk++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL nom_release got %b want 10", {in_ready, out_valid}); else n_pass++;
  endtask

  task automatic test_prefill();
    logic [127:0] w2;
    do_reset();
    set_job(); in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (5) tick();
    n_chk++; if ({core_rst, in_ready} !== 2'b10) $display("FAIL pre_wait got %b want 10", {core_rst, in_ready}); else n_pass++;
    rnd_valid = 1'b1;
    tick();
    w2 = rnd_data;
    tick();
    rnd_valid = 1'b0;
    n_chk++; if (core_rst !== 1'b1) $display("FAIL pre_still_fill got %b want 1", core_rst); else n_pass++;
    tick();
    n_chk++; if (core_rst !== 1'b0) $display("FAIL pre_run got %b want 0", core_rst); else n_pass++;
    n_chk++; if (core_ri !== w2) $display("FAIL pre_head got %h want %h", core_ri, w2); else n_pass++;
  endtask

  task automatic test_starvation();
    int n, k;
    bit saw_out;
    do_reset();
    rnd_valid = 1'b1;
    repeat (6) tick();
    n_chk++; if (rnd_ready !== 1'b0) $display("FAIL starve_full got %b want 0", rnd_ready); else n_pass++;
    set_job(); in_valid = 1'b1; tick(); in_valid = 1'b0;
    wait_run(n);
    rnd_valid = 1'b0;
    saw_out = 1'b0; k = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid) saw_out = 1'b1;
      if (err) begin k = i; break; end
    end
    n_chk++; if (k != 25) $display("FAIL starve_cycles got %0d want 25", k); else n_pass++;
    n_chk++; if (saw_out !== 1'b0) $display("FAIL starve_no_out got %b want 0", saw_out); else n_pass++;
    n_chk++; if ({in_ready, core_rst} !== 2'b11) $display("FAIL starve_idle got %b want 11", {in_ready, core_rst}); else n_pass++;
    core_done = 1'b1; repeat (3) tick(); core_done = 1'b0;
    n_chk++; if ({err, out_valid} !== 2'b10) $display("FAIL starve_sticky got %b want 10", {err, out_valid}); else n_pass++;
  endtask

  task automatic test_midrun_rst();
    int n;
    rnd_valid = 1'b1;
    repeat (4) tick();
    set_job(); in_valid = 1'b1; tick(); in_valid = 1'b0;
    wait_run(n);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0; rnd_valid = 1'b0;
    n_chk++; if ({in_ready, out_valid, err, core_rst, rnd_ready} !== 5'b10011)
      $display("FAIL mid_rst got %b want 10011", {in_ready, out_valid, err, core_rst, rnd_ready}); else n_pass++;
    n_chk++; if (core_sshi0 !== '0) $display("FAIL mid_rst_job got %h want 0", core_sshi0); else n_pass++;
    set_job(); in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (6) tick();
    n_chk++; if (core_rst !== 1'b1) $display("FAIL mid_flushed got %b want 1", core_rst); else n_pass++;
  endtask

  task automatic test_backpressure();
    int n;
    logic [127:0] r0, r1;
    do_reset();
    rnd_valid = 1'b1;
    repeat (4) tick();
    set_job(); in_valid = 1'b1; tick(); in_valid = 1'b0;
    wait_run(n);
    repeat (3) tick();
    r0 = r128(); r1 = r128();
    core_sshr0 = r0; core_sshr1 = r1; core_done = 1'b1;
    tick(); core_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin core_sshr0 = r128(); core_sshr1 = r128(); core_done = 1'b1; end
      if (i == 5) core_done = 1'b0;
      n_chk++; if ({out_valid, in_ready} !== 2'b10 || {out_ssh0, out_ssh1} !== {r0, r1})
        $display("FAIL bp_hold cyc %0d got v%b r%b %h want v1 r0 %h", i, out_valid, in_ready, out_ssh0, r0); else n_pass++;
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_chk++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release got %b want 10", {in_ready, out_valid}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n, dup;
    logic [127:0] res [2];
    do_reset();
    m_used.delete();
    rnd_valid = 1'b1; out_ready = 1'b1;
    repeat (4) tick();
    set_job(); in_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      logic [127:0] exp0, exp4;
      exp0 = job[0]; exp4 = job[4];
      n_chk++; if (in_ready !== 1'b1) $display("FAIL b2b_ready job %0d got %b want 1", j, in_ready); else n_pass++;
      tick();
      if (j == 0) set_job();
      else in_valid = 1'b0;
      n_chk++; if ({core_sshi0, core_ti} !== {exp0, exp4}) $display("FAIL b2b_job %0d got %h want %h", j, core_sshi0, exp0); else n_pass++;
      wait_run(n);
      repeat (6 + 3 * j) tick();
      res[j] = r128();
      core_sshr0 = res[j]; core_sshr1 = ~res[j]; core_done = 1'b1;
      tick(); core_done = 1'b0;
      n_chk++; if ({out_valid, out_ssh0, out_ssh1} !== {1'b1, res[j], ~res[j]})
        $display("FAIL b2b_result %0d got %b %h want 1 %h", j, out_valid, out_ssh0, res[j]); else n_pass++;
      tick();
    end
    dup = 0;
    for (int a = 0; a < m_used.size(); a++)
      for (int b = a + 1; b < m_used.size(); b++)
        if (m_used[a] === m_used[b]) dup++;
    n_chk++; if (dup != 0) $display("FAIL b2b_mask_reuse got %0d want 0", dup); else n_pass++;
    out_ready = 1'b0; rnd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_prefill();
    test_starvation();
    test_midrun_rst();
    test_backpressure();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
